// File: rtl/fifo_mux_rr_if.sv
// fifo_mux_rr_if
// Groups the handshake and data signals of the packet multiplexer.
//   data_i     NUM_PORTS*WIDTH  input words, port n at [n*WIDTH +: WIDTH]
//   src_rdy_i  NUM_PORTS        per-port source valid
//   dst_rdy_o  NUM_PORTS        per-port accept
//   data_o     WIDTH            output word (head of output FIFO)
//   port_o     PORTW            index of the port that sourced data_o
//   src_rdy_o  1                output valid
//   dst_rdy_i  1                downstream accept
// Modport slave is the multiplexer side, master is the traffic side.
interface fifo_mux_rr_if #(
  parameter int WIDTH     = 36,
  parameter int NUM_PORTS = 4,
  parameter int PORTW     = 2
);
  logic [NUM_PORTS*WIDTH-1:0] data_i;
  logic [NUM_PORTS-1:0]       src_rdy_i;
  logic [NUM_PORTS-1:0]       dst_rdy_o;
  logic [WIDTH-1:0]           data_o;
  logic [PORTW-1:0]           port_o;
  logic                       src_rdy_o;
  logic                       dst_rdy_i;

  modport slave (
    input  data_i, src_rdy_i, dst_rdy_i,
    output dst_rdy_o, data_o, port_o, src_rdy_o
  );

  modport master (
    output data_i, src_rdy_i, dst_rdy_i,
    input  dst_rdy_o, data_o, port_o, src_rdy_o
  );
endinterface

// File: rtl/fifo_mux_rr.sv
// fifo_mux_rr
// Packet multiplexer: NUM_PORTS input streams are merged into one output
// stream without interleaving packets. A packet ends on a beat whose
// EOF_BIT is set. Arbitration is round-robin (PRIO=0) or fixed priority
// with lowest index winning (PRIO=1). Each grant costs one idle cycle.
// Accepted beats go through a 2-entry {port, data} FIFO to the output.
// Ports:
//   clk    clock, all logic on rising edge
//   reset  asynchronous active-high reset
//   clear  synchronous active-high flush, same effect as reset
//   bus    fifo_mux_rr_if.slave carrying all handshake/data signals
module fifo_mux_rr #(
  parameter int WIDTH     = 36,
  parameter int NUM_PORTS = 4,
  parameter int PORTW     = 2,
  parameter int EOF_BIT   = 33,
  parameter int PRIO      = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  fifo_mux_rr_if.slave  bus
);

  localparam int EW = WIDTH + PORTW;

  typedef enum logic {IDLE, DATA} state_t;

  state_t           state, state_next;
  logic [PORTW-1:0] gnt, gnt_next;
  logic [PORTW-1:0] last, last_next;
  logic [PORTW-1:0] sel;
  logic             found;
  logic             any_req;
  logic [WIDTH-1:0] cur_data;
  logic             cur_req;
  logic             int_rdy;
  logic             accept;
  logic             eof_beat;
  logic             pop;

  logic [EW-1:0]    mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;

  assign any_req = |bus.src_rdy_i;

  // Port selection for the next grant. Round-robin scans upward starting
  // one past the last port served, so that port is considered last.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    if (PRIO != 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (bus.src_rdy_i[i]) sel = PORTW'(i);
      end
    end else begin
      for (int i = 1; i <= NUM_PORTS; i++) begin
        if (!found && bus.src_rdy_i[(int'(last) + i) % NUM_PORTS]) begin
          sel   = PORTW'((int'(last) + i) % NUM_PORTS);
          found = 1'b1;
        end
      end
    end
  end

  // Route the granted port's word and valid; only that port may be ready.
  always_comb begin
    cur_data      = '0;
    cur_req       = 1'b0;
    bus.dst_rdy_o = '0;
    for (int n = 0; n < NUM_PORTS; n++) begin
      if (gnt == PORTW'(n)) begin
        cur_data = bus.data_i[n*WIDTH +: WIDTH];
        cur_req  = bus.src_rdy_i[n];
        if (state == DATA) bus.dst_rdy_o[n] = int_rdy;
      end
    end
  end

  assign int_rdy  = (count != 2'd2);
  assign accept   = (state == DATA) && cur_req && int_rdy;
  assign eof_beat = accept && cur_data[EOF_BIT];
  assign pop      = bus.src_rdy_o && bus.dst_rdy_i;

  // Arbiter next state: grant in IDLE, hold the grant until the EOF beat.
  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    last_next  = last;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_next   = sel;
          state_next = DATA;
        end
      end
      DATA: begin
        if (eof_beat) begin
          last_next  = gnt;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= PORTW'(NUM_PORTS - 1);
    end else if (clear) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= PORTW'(NUM_PORTS - 1);
    end else begin
      state <= state_next;
      gnt   <= gnt_next;
      last  <= last_next;
    end
  end

  // Output FIFO bookkeeping; clear drops everything buffered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr ^ accept;
      rd_ptr <= rd_ptr ^ pop;
      count  <= count + {1'b0, accept} - {1'b0, pop};
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {gnt, cur_data};
  end

  assign bus.src_rdy_o = (count != 2'd0);
  assign bus.data_o    = mem[rd_ptr][WIDTH-1:0];
  assign bus.port_o    = mem[rd_ptr][EW-1:WIDTH];

endmodule

// File: doc/fifo_mux_rr.md
FIFO_MUX_RR -- requirements
Module: fifo_mux_rr

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH  36  data bus width per port, including flag bits.
  NUM_PORTS  4  number of input ports, 2..16.
  PORTW  2  port-index width, ceil(log2(NUM_PORTS)), minimum 1.
  EOF_BIT  33  bit position of the end-of-packet flag within a data word.
  PRIO  0  0 = round-robin arbitration; 1 = fixed priority, lowest index wins.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all logic is posedge clk.
  reset  in  1  asynchronous, active-high reset.
  clear  in  1  synchronous flush, active-high.
  data_i  in  NUM_PORTS*WIDTH  input words; port n occupies bits [n*WIDTH +: WIDTH].
  src_rdy_i  in  NUM_PORTS  per-port source valid.
  dst_rdy_o  out  NUM_PORTS  per-port accept.
  data_o  out  WIDTH  output word.
  port_o  out  PORTW  index of the port that sourced data_o.
  src_rdy_o  out  1  output valid.
  dst_rdy_i  in  1  downstream accept.
REQ-003 Port n SHALL transfer a beat in any cycle where src_rdy_i[n] and dst_rdy_o[n] are both 1; the output SHALL transfer when src_rdy_o and dst_rdy_i are both 1.

Function
REQ-004 The arbiter SHALL have exactly two states: IDLE and DATA. It SHALL hold a grant register gnt of PORTW bits and a last-served register last of PORTW bits.
REQ-005 In IDLE, when any src_rdy_i bit is 1, the block SHALL load gnt with the selected port and enter DATA on the next edge. No beat SHALL be accepted in the IDLE cycle, so there is a one-cycle arbitration bubble per packet.
REQ-006 Round-robin mode (PRIO=0): the selected port SHALL be the first requesting port found scanning (last+1) mod NUM_PORTS upward, with wrap-around.
REQ-007 Priority mode (PRIO=1): the selected port SHALL be the lowest-index requesting port; the last register has no effect.
REQ-008 In DATA, dst_rdy_o[gnt] SHALL equal int_rdy. Every other dst_rdy_o bit SHALL be 0. In IDLE, all dst_rdy_o bits SHALL be 0.
REQ-009 In DATA, when a beat transfers from port gnt with data bit EOF_BIT set, the block SHALL set last to gnt and return to IDLE on the same edge.
REQ-010 Packets SHALL never be interleaved. Once granted, a port keeps the grant through its EOF beat regardless of other requests or stalls, and regardless of src_rdy_i[gnt] dropping mid-packet.
REQ-011 Output stage: a 2-entry FIFO of WIDTH+PORTW bits holding {port, data}.
  - int_rdy SHALL be 1 when the FIFO is not full.
  - Each accepted input beat SHALL be written with port=gnt.
  - src_rdy_o SHALL be 1 when the FIFO is not empty.
  - data_o and port_o SHALL present the head entry.
REQ-012 Latency: a beat accepted at edge k SHALL be visible on data_o and port_o after edge k when the FIFO was empty. Simultaneous write and read on a non-empty FIFO SHALL preserve order and occupancy.
REQ-013 Full boundary: with 2 entries held and dst_rdy_i=0, int_rdy SHALL be 0 and no beat SHALL be accepted. Empty boundary: src_rdy_o SHALL be 0 and data_o is don't-care.
REQ-014 Sustained throughput SHALL be one beat per cycle within a packet when dst_rdy_i is held at 1.
REQ-015 Single-port traffic in round-robin mode SHALL be re-granted to the same port after its own packet, with one bubble per packet.

Reset
REQ-016 On reset=1 (asynchronous), the block SHALL immediately set: state=IDLE, gnt=0, last=NUM_PORTS-1, FIFO empty, src_rdy_o=0, all dst_rdy_o=0. data_o and port_o are don't-care.
REQ-017 On clear=1 at a clock edge, the block SHALL apply the same values as reset, synchronously. A packet in flight SHALL be abandoned, and the next grant SHALL start a fresh packet.
REQ-018 Reset or clear asserted mid-packet SHALL discard the buffered beats. No partial packet SHALL be emitted afterwards.

Verification
REQ-019 Reset, then ports 0..3 each continuously offer a 3-beat packet, PRIO=0, dst_rdy_i=1 -> output port order 0,1,2,3,0. Each packet is 3 contiguous beats with EOF on the 3rd, followed by a 1-cycle gap.
REQ-020 PRIO=1 with ports 0 and 2 continuously requesting -> only port 0 packets are output; port 2 never sees dst_rdy_o=1.
REQ-021 Port 1 packet in progress, port 0 requests mid-packet, dst_rdy_i toggles 1,0,1,0 -> port 1 beats are output in order with no interleave, and port 0 is granted after EOF.
REQ-022 dst_rdy_i=0 for 5 cycles during a 4-beat packet -> exactly 2 beats buffered, dst_rdy_o[gnt]=0 from the 3rd cycle, and no beat is lost or duplicated after release.
REQ-023 Assert reset asynchronously between edges mid-packet -> src_rdy_o=0 and dst_rdy_o=0 immediately. The first packet after release is granted to port 0, using round-robin from last=NUM_PORTS-1.
REQ-024 clear pulsed for 1 cycle with 2 entries buffered -> src_rdy_o=0 on the next cycle and state=IDLE. Only beats offered after the clear are subsequently output.
